// File: rtl/fir_filter.sv
// Serial-MAC FIR stage: one time-shared multiplier, NTAPS clocks per sample.
// Runtime-writable Q1.15 coefficients, rounded and saturated output.
module fir_filter #(
    parameter int NTAPS     = 16,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15,
    localparam int AW       = $clog2(NTAPS)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     overrun_o,
    input  logic                     coef_we_i,
    input  logic [AW-1:0]            coef_addr_i,
    input  logic signed [COEF_W-1:0] coef_data_i
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic signed [COEF_W-1:0] COEF_RST =
        COEF_W'((1 << COEF_FRAC) / NTAPS);
    localparam logic signed [ACC_W:0] HALF =
        (ACC_W+1)'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W:0] SMAX =
        (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SMIN = -SMAX - 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                    state_q;
    logic signed [DATA_W-1:0]  dly_q  [NTAPS];
    logic signed [COEF_W-1:0]  coef_q [NTAPS];
    logic [AW-1:0]             wp_q;
    logic [AW-1:0]             k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  data_q;
    logic                      valid_q;
    logic                      ovr_q;

    logic [AW-1:0]             tap_idx;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W:0]     rnd;
    logic signed [ACC_W:0]     shifted;
    logic signed [DATA_W-1:0]  sat_d;

    // wp_q already points past the newest sample, so x[k] sits at wp-1-k
    assign tap_idx = wp_q - AW'(1) - k_q;
    assign prod    = PROD_W'(dly_q[tap_idx]) * PROD_W'(coef_q[k_q]);
    assign rnd     = (ACC_W+1)'(acc_q) + HALF;
    assign shifted = rnd >>> COEF_FRAC;

    always_comb begin
        sat_d = shifted[DATA_W-1:0];
        if (shifted > SMAX) begin
            sat_d = SMAX[DATA_W-1:0];
        end else if (shifted < SMIN) begin
            sat_d = SMIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wp_q    <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                dly_q[i]  <= '0;
                coef_q[i] <= COEF_RST;
            end
        end else begin
            valid_q <= 1'b0;
            if (coef_we_i && state_q == IDLE) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
            if (valid_i && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        dly_q[wp_q] <= data_i;
                        wp_q        <= wp_q + AW'(1);
                        acc_q       <= '0;
                        k_q         <= '0;
                        state_q     <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    k_q   <= k_q + AW'(1);
                    if (k_q == AW'(NTAPS - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    data_q  <= sat_d;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != IDLE);
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed testbench for fir_filter: impulse, step, saturation,
// timing/overrun, mid-op reset and coefficient write vectors.
module tb_fir_filter;

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b0;
    logic               valid_i = 1'b0;
    logic signed [15:0] data_i = '0;
    logic signed [15:0] data_o;
    logic               valid_o;
    logic               busy_o;
    logic               overrun_o;
    logic               coef_we_i = 1'b0;
    logic [3:0]         coef_addr_i = '0;
    logic signed [15:0] coef_data_i = '0;

    int n_cmp = 0;
    int n_bad = 0;

    fir_filter dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_data_i (coef_data_i)
    );

    always #10 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic wr_coef(input int a, input int v);
        @(negedge clk_i);
        coef_we_i   = 1'b1;
        coef_addr_i = 4'(a);
        coef_data_i = 16'(v);
        @(negedge clk_i);
        coef_we_i = 1'b0;
    endtask

    // returns output value and latency in edges after acceptance (-1 on timeout)
    task automatic send(input int s, output int y, output int lat);
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 16'(s);
        @(negedge clk_i);
        valid_i = 1'b0;
        y   = 0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                y   = data_o;
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("send_timeout", lat, 17);
    endtask

    task automatic wait_out(input string tag);
        int seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                seen = 1;
                break;
            end
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, lat, cnt;

        do_reset();
        #1;
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovr", overrun_o, 0);

        // impulse
        for (int n = 0; n < 18; n++) begin
            send(n == 0 ? 32767 : 0, y, lat);
            if (n == 0) chk("imp_lat", lat, 17);
            chk($sformatf("imp%0d", n), y, n < 16 ? 2048 : 0);
        end

        // step
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            send(1000, y, lat);
            chk($sformatf("step%0d", n), y, n >= 16 ? 1000 : (125 * n + 1) / 2);
        end

        // saturation
        do_reset();
        for (int i = 0; i < 16; i++) wr_coef(i, 32767);
        for (int n = 0; n < 16; n++) send(32767, y, lat);
        chk("sat_pos", y, 32767);
        for (int n = 0; n < 16; n++) send(-32768, y, lat);
        chk("sat_neg", y, -32768);

        // timing and overrun; the dropped 8000 must not enter the line
        do_reset();
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 16'sd16000;
        @(posedge clk_i);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            valid_i = (c == 5);
            data_i  = 16'sd8000;
            @(posedge clk_i);
            #1;
            chk($sformatf("tim_valid%0d", c), valid_o, c == 17 ? 1 : 0);
            chk($sformatf("tim_busy%0d", c), busy_o, c <= 16 ? 1 : 0);
            if (c == 17) chk("tim_data", data_o, 1000);
        end
        chk("ovr_set", overrun_o, 1);
        send(0, y, lat);
        chk("drop_unchanged", y, 1000);
        chk("ovr_sticky", overrun_o, 1);
        do_reset();
        #1;
        chk("ovr_clr", overrun_o, 0);

        // reset mid-op, coefficients perturbed first
        wr_coef(0, 100);
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 16'sd20000;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) cnt++;
        end
        chk("mid_novalid", cnt, 0);
        chk("mid_data", data_o, 0);
        chk("mid_busy", busy_o, 0);
        for (int n = 0; n < 17; n++) begin
            send(n == 0 ? 32767 : 0, y, lat);
            chk($sformatf("mid_imp%0d", n), y, n < 16 ? 2048 : 0);
        end

        // single-tap coefficient set
        do_reset();
        wr_coef(0, 16384);
        for (int i = 1; i < 16; i++) wr_coef(i, 0);
        send(1000, y, lat);
        chk("cw_pos", y, 500);
        send(-1001, y, lat);
        chk("cw_neg", y, -500);
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 16'sd1000;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        coef_we_i   = 1'b1;
        coef_addr_i = 4'd0;
        coef_data_i = 16'sd0;
        @(negedge clk_i);
        coef_we_i = 1'b0;
        wait_out("cw_busy_done");
        chk("cw_busy_out", data_o, 500);
        send(1000, y, lat);
        chk("cw_busy_ignored", y, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
